// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
//
// Merges NUM_SRC AXI-Stream sources into one output stream, one whole packet
// at a time. When idle, the next owner is chosen round-robin: the scan starts
// at the index after the most recent winner and moves upward modulo NUM_SRC.
// Ownership is held until the owner's tlast beat transfers. Data is not
// buffered: the granted source is muxed straight through to the output.
//
// Ports
//   aclk      : clock, all logic on the rising edge
//   areset    : synchronous active-high reset
//   s_tvalid  : per-source valid                         [NUM_SRC]
//   s_tlast   : per-source last beat of packet           [NUM_SRC]
//   s_tdata   : per-source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tready  : per-source ready, only the owner may see m_tready
//   m_tvalid  : merged-stream valid
//   m_tlast   : merged-stream last
//   m_tdata   : merged-stream data                       [DATA_WIDTH]
//   m_tready  : downstream ready
//   grant     : registered one-hot owner, 0 when idle    [NUM_SRC]
//   busy      : registered, high while a packet is owned
//   pkt_cnt   : packets forwarded, wraps at 16 bits
// ---------------------------------------------------------------------------
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    input  logic [NUM_SRC-1:0]            s_tlast,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
    output logic [NUM_SRC-1:0]            s_tready,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    input  logic                          m_tready,
    output logic [NUM_SRC-1:0]            grant,
    output logic                          busy,
    output logic [15:0]                   pkt_cnt
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;   // most recent winner; also the owner while in PASS
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;

    logic               winner_found;
    logic [IDX_W-1:0]   winner_idx;
    logic               xfer_last;

    // -----------------------------------------------------------------------
    // Round-robin pick: first requesting index after last_idx_q, wrapping.
    // Evaluated every cycle but only consumed in IDLE.
    // -----------------------------------------------------------------------
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path through the block leaves it unassigned (no latch).
        winner_found = 1'b0;
        winner_idx   = '0;
        cand         = 0;
        cand_idx     = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand     = (int'(last_idx_q) + k) % NUM_SRC;
            cand_idx = IDX_W'(cand);
            if (!winner_found && s_tvalid[cand_idx]) begin
                winner_found = 1'b1;
                winner_idx   = cand_idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Zero-cycle pass-through of the owner. Reset forces the stream handshake
    // low immediately so an abandoned packet cannot move another beat.
    // -----------------------------------------------------------------------
    always_comb begin
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = '0;
        s_tready = '0;
        if (state_q == PASS && !areset) begin
            m_tvalid             = s_tvalid[last_idx_q];
            m_tlast              = s_tlast[last_idx_q];
            m_tdata              = s_tdata[last_idx_q*DATA_WIDTH +: DATA_WIDTH];
            s_tready[last_idx_q] = m_tready;
        end
    end

    assign xfer_last = m_tvalid & m_tready & m_tlast;

    // -----------------------------------------------------------------------
    // Next-state logic. The tlast edge only returns to IDLE; the next winner
    // is picked on the following edge, leaving one idle cycle between packets.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_idx_d = last_idx_q;
        pkt_cnt_d  = pkt_cnt_q;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    state_d             = PASS;
                    grant_d             = '0;
                    grant_d[winner_idx] = 1'b1;
                    last_idx_d          = winner_idx;
                end
            end
            PASS: begin
                // Ownership only ends on a completed tlast beat; a source
                // dropping tvalid mid-packet keeps the lock.
                if (xfer_last) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers. Reset leaves last_idx at NUM_SRC-1 so source 0 is
    // scanned first.
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (areset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_idx_q <= IDX_W'(NUM_SRC - 1);
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q == PASS);
    assign pkt_cnt = pkt_cnt_q;

endmodule
